// File: rtl/simd_pipe_ctrl.sv
// rtl/simd_pipe_ctrl.sv - issue/LOAD/EXEC/STORE control pipeline for the SIMD datapath
module simd_pipe_ctrl #(
  parameter int ADDR_WIDTH     = 10,
  parameter int OP_SEL_WIDTH   = 3,
  parameter int ISSUE_INTERVAL = 2,
  parameter int EXEC_STAGES    = 1,
  parameter int HAZARD_CHECK   = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_a_addr,
  input  logic [ADDR_WIDTH-1:0]   in_b_addr,
  input  logic [ADDR_WIDTH-1:0]   in_r_addr,
  input  logic [OP_SEL_WIDTH-1:0] in_pe_op,
  input  logic [1:0]              in_dot_ctrl,
  input  logic                    in_wen,
  input  logic                    in_rsel,
  input  logic                    flush,
  output logic                    adv,
  output logic [ADDR_WIDTH-1:0]   bram_a_addr,
  output logic [ADDR_WIDTH-1:0]   bram_b_addr,
  output logic                    exec_valid,
  output logic [OP_SEL_WIDTH-1:0] exec_pe_op,
  output logic [1:0]              exec_dot_ctrl,
  output logic [ADDR_WIDTH-1:0]   bram_r_addr,
  output logic                    bram_r_wen,
  output logic                    r_select,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    issue_cnt,
  output logic [CNT_WIDTH-1:0]    stall_cnt
);

  // Stage index 0 is LOAD, 1..EXEC_STAGES are EXEC, the last one is STORE.
  localparam int NS   = EXEC_STAGES + 2;
  localparam int ST   = NS - 1;
  localparam int PH_W = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(ISSUE_INTERVAL - 1);

  logic [PH_W-1:0]         phase;
  logic [NS-1:0]           st_valid;
  logic [NS-1:0]           st_wen;
  logic [NS-1:0]           st_rsel;
  logic [ADDR_WIDTH-1:0]   st_r   [NS];
  // op/dot are only consumed up to the last EXEC stage, A/B only in LOAD.
  logic [OP_SEL_WIDTH-1:0] st_op  [EXEC_STAGES+1];
  logic [1:0]              st_dot [EXEC_STAGES+1];
  logic [ADDR_WIDTH-1:0]   ld_a;
  logic [ADDR_WIDTH-1:0]   ld_b;
  logic                    hit;
  logic                    hazard;
  logic                    take;

  // RAW match against every writing stage that survives this advance (STORE retires, so skip it)
  always_comb begin
    hit = 1'b0;
    for (int s = 0; s < ST; s++) begin
      if (st_valid[s] && st_wen[s] &&
          (st_r[s] == in_a_addr || st_r[s] == in_b_addr)) begin
        hit = 1'b1;
      end
    end
  end

  assign hazard   = (HAZARD_CHECK != 0) && in_valid && hit;
  // Gated by rstn so that adv is 0 while reset is held, even with a one-cycle interval.
  assign adv      = rstn && (phase == PH_LAST);
  assign in_ready = adv && !hazard;
  assign take     = in_valid && in_ready && !flush;

  // Phase counter: wraps at ISSUE_INTERVAL-1, restarted by flush
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase <= '0;
    end else if (flush || adv) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  // Stage shift register: everything moves one place per advance, LOAD takes the input or a bubble
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_valid <= '0;
      st_wen   <= '0;
      st_rsel  <= '0;
      ld_a     <= '0;
      ld_b     <= '0;
      for (int s = 0; s < NS; s++) st_r[s] <= '0;
      for (int s = 0; s <= EXEC_STAGES; s++) begin
        st_op[s]  <= '0;
        st_dot[s] <= '0;
      end
    end else if (flush) begin
      st_valid <= '0;
      st_wen   <= '0;
      st_rsel  <= '0;
      ld_a     <= '0;
      ld_b     <= '0;
      for (int s = 0; s < NS; s++) st_r[s] <= '0;
      for (int s = 0; s <= EXEC_STAGES; s++) begin
        st_op[s]  <= '0;
        st_dot[s] <= '0;
      end
    end else if (adv) begin
      st_valid <= {st_valid[NS-2:0], take};
      st_wen   <= {st_wen[NS-2:0], take && in_wen};
      st_rsel  <= {st_rsel[NS-2:0], take && in_rsel};
      ld_a     <= take ? in_a_addr : '0;
      ld_b     <= take ? in_b_addr : '0;
      for (int s = ST; s > 0; s--) st_r[s] <= st_r[s-1];
      st_r[0] <= take ? in_r_addr : '0;
      for (int s = EXEC_STAGES; s > 0; s--) begin
        st_op[s]  <= st_op[s-1];
        st_dot[s] <= st_dot[s-1];
      end
      st_op[0]  <= take ? in_pe_op : '0;
      st_dot[0] <= take ? in_dot_ctrl : '0;
    end
  end

  // Saturating issue and stall counters; a flushed handshake counts as neither
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (take && (issue_cnt != '1)) issue_cnt <= issue_cnt + 1'b1;
      if (adv && hazard && !flush && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bram_a_addr   = ld_a;
  assign bram_b_addr   = ld_b;
  assign exec_valid    = st_valid[EXEC_STAGES];
  assign exec_pe_op    = st_valid[EXEC_STAGES] ? st_op[EXEC_STAGES] : '0;
  assign exec_dot_ctrl = st_valid[EXEC_STAGES] ? st_dot[EXEC_STAGES] : '0;
  assign bram_r_addr   = st_r[ST];
  assign bram_r_wen    = st_valid[ST] && st_wen[ST];
  assign r_select      = st_rsel[ST];
  assign busy          = |st_valid;

endmodule

// File: tb/tb_simd_pipe_ctrl.sv
// tb/tb_simd_pipe_ctrl.sv - self-checking bench for simd_pipe_ctrl (three parameter sets)
module tb_simd_pipe_ctrl;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic       iv[3], iwen[3], irsel[3], ifl[3];
  logic [9:0] ia[3], ib[3], ir[3];
  logic [2:0] iop[3];
  logic [1:0] idot[3];

  logic        o_adv[3], o_ready[3], o_ev[3], o_rwen[3], o_rsel[3], o_busy[3];
  logic [9:0]  o_aaddr[3], o_baddr[3], o_raddr[3];
  logic [2:0]  o_op[3];
  logic [1:0]  o_dot[3];
  logic [15:0] o_ic[3], o_sc[3];

  // Instance 0: defaults. Instance 1: interval 1, three EXEC stages. Instance 2: 2-bit counters, no hazard check.
  int P_II[3] = '{2, 1, 2};
  int P_E[3]  = '{1, 3, 1};
  int P_HC[3] = '{1, 1, 0};
  int P_CW[3] = '{16, 16, 2};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int II = (g == 1) ? 1 : 2;
    localparam int ES = (g == 1) ? 3 : 1;
    localparam int HC = (g == 2) ? 0 : 1;
    localparam int CW = (g == 2) ? 2 : 16;
    logic [CW-1:0] ic, sc;
    simd_pipe_ctrl #(
      .ADDR_WIDTH(10), .OP_SEL_WIDTH(3), .ISSUE_INTERVAL(II),
      .EXEC_STAGES(ES), .HAZARD_CHECK(HC), .CNT_WIDTH(CW)
    ) u_dut (
      .clk(clk), .rstn(rstn),
      .in_valid(iv[g]), .in_ready(o_ready[g]),
      .in_a_addr(ia[g]), .in_b_addr(ib[g]), .in_r_addr(ir[g]),
      .in_pe_op(iop[g]), .in_dot_ctrl(idot[g]), .in_wen(iwen[g]), .in_rsel(irsel[g]),
      .flush(ifl[g]), .adv(o_adv[g]),
      .bram_a_addr(o_aaddr[g]), .bram_b_addr(o_baddr[g]),
      .exec_valid(o_ev[g]), .exec_pe_op(o_op[g]), .exec_dot_ctrl(o_dot[g]),
      .bram_r_addr(o_raddr[g]), .bram_r_wen(o_rwen[g]), .r_select(o_rsel[g]),
      .busy(o_busy[g]), .issue_cnt(ic), .stall_cnt(sc)
    );
    assign o_ic[g] = 16'(ic);
    assign o_sc[g] = 16'(sc);
  end

  // Reference model: a pool of in-flight instructions, each tagged with the number of advances since accept.
  typedef struct {
    bit         act;
    int         age;
    logic [9:0] a, b, r;
    logic [2:0] op;
    logic [1:0] dot;
    logic       wen, rsel;
  } rec_t;

  rec_t m[3][8];
  int   m_ph[3], m_ic[3], m_sc[3];
  bit   m_acc[3];
  int   checks = 0;
  int   errors = 0;
  int   edges = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_adv(input int k);
    return rstn && (m_ph[k] == P_II[k] - 1);
  endfunction

  function automatic bit m_hazard(input int k);
    if (P_HC[k] == 0 || !iv[k]) return 1'b0;
    for (int j = 0; j < 8; j++)
      if (m[k][j].act && m[k][j].age <= P_E[k] && m[k][j].wen &&
          (m[k][j].r == ia[k] || m[k][j].r == ib[k])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) m[k][j].act = 1'b0;
      m_ph[k] = 0; m_ic[k] = 0; m_sc[k] = 0; m_acc[k] = 1'b0;
    end
  endtask

  task automatic check_outputs(input int k);
    logic [9:0] ea, eb, er;
    logic [2:0] eop;
    logic [1:0] edot;
    logic       ev, ew, es, ebusy, eadv;
    ea = '0; eb = '0; er = '0; eop = '0; edot = '0;
    ev = 1'b0; ew = 1'b0; es = 1'b0; ebusy = 1'b0;
    eadv = m_adv(k);
    for (int j = 0; j < 8; j++) begin
      if (m[k][j].act) begin
        ebusy = 1'b1;
        if (m[k][j].age == 0) begin ea = m[k][j].a; eb = m[k][j].b; end
        if (m[k][j].age == P_E[k]) begin ev = 1'b1; eop = m[k][j].op; edot = m[k][j].dot; end
        if (m[k][j].age == P_E[k] + 1) begin er = m[k][j].r; ew = m[k][j].wen; es = m[k][j].rsel; end
      end
    end
    check($sformatf("u%0d adv", k), 32'(o_adv[k]), 32'(eadv));
    check($sformatf("u%0d in_ready", k), 32'(o_ready[k]), 32'(eadv && !m_hazard(k)));
    check($sformatf("u%0d bram_a_addr", k), 32'(o_aaddr[k]), 32'(ea));
    check($sformatf("u%0d bram_b_addr", k), 32'(o_baddr[k]), 32'(eb));
    check($sformatf("u%0d exec_valid", k), 32'(o_ev[k]), 32'(ev));
    check($sformatf("u%0d exec_pe_op", k), 32'(o_op[k]), 32'(eop));
    check($sformatf("u%0d exec_dot_ctrl", k), 32'(o_dot[k]), 32'(edot));
    check($sformatf("u%0d bram_r_addr", k), 32'(o_raddr[k]), 32'(er));
    check($sformatf("u%0d bram_r_wen", k), 32'(o_rwen[k]), 32'(ew));
    check($sformatf("u%0d r_select", k), 32'(o_rsel[k]), 32'(es));
    check($sformatf("u%0d busy", k), 32'(o_busy[k]), 32'(ebusy));
    check($sformatf("u%0d issue_cnt", k), 32'(o_ic[k]), 32'(m_ic[k]));
    check($sformatf("u%0d stall_cnt", k), 32'(o_sc[k]), 32'(m_sc[k]));
  endtask

  task automatic update_model(input int k);
    bit adv, hz, placed;
    int cmax;
    adv = m_adv(k);
    hz = m_hazard(k);
    cmax = (1 << P_CW[k]) - 1;
    m_acc[k] = 1'b0;
    if (ifl[k]) begin
      for (int j = 0; j < 8; j++) m[k][j].act = 1'b0;
      m_ph[k] = 0;
      return;
    end
    if (adv) begin
      for (int j = 0; j < 8; j++)
        if (m[k][j].act) begin
          m[k][j].age++;
          if (m[k][j].age > P_E[k] + 1) m[k][j].act = 1'b0;
        end
      if (iv[k] && hz && m_sc[k] < cmax) m_sc[k]++;
      if (iv[k] && !hz) begin
        placed = 1'b0;
        for (int j = 0; j < 8; j++)
          if (!placed && !m[k][j].act) begin
            m[k][j] = '{1'b1, 0, ia[k], ib[k], ir[k], iop[k], idot[k], iwen[k], irsel[k]};
            placed = 1'b1;
          end
        if (m_ic[k] < cmax) m_ic[k]++;
        m_acc[k] = 1'b1;
      end
    end
    m_ph[k] = adv ? 0 : m_ph[k] + 1;
  endtask

  // One clock: compare on the falling edge, advance the model to the next rising edge.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_outputs(k);
      update_model(k);
    end
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic set_in(input int k, input bit v, input int a, input int b, input int r,
                        input int op, input int dot, input bit wen, input bit rsel);
    iv[k] = v; ia[k] = 10'(a); ib[k] = 10'(b); ir[k] = 10'(r);
    iop[k] = 3'(op); idot[k] = 2'(dot); iwen[k] = wen; irsel[k] = rsel;
  endtask

  task automatic issue(input int k, input int a, input int b, input int r, input int op,
                       input int dot, input bit wen, input bit rsel, output int w);
    set_in(k, 1'b1, a, b, r, op, dot, wen, rsel);
    w = 0;
    do begin
      cycle();
      w++;
    end while (!m_acc[k] && w < 40);
    check($sformatf("u%0d issue accepted", k), 32'(m_acc[k]), 32'd1);
    iv[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (o_busy[k] && n < 30) begin
      cycle();
      n++;
    end
    check($sformatf("u%0d drained", k), 32'(o_busy[k]), 32'd0);
  endtask

  initial begin
    int w, n1, nl, base, seen;
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(k, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      ifl[k] = 1'b0;
    end
    model_reset();
    #2;
    for (int k = 0; k < 3; k++) check_outputs(k);
    @(posedge clk);
    #3;
    rstn = 1'b1;

    // Two independent instructions on the default configuration
    issue(0, 1, 2, 10, 1, 1, 1'b1, 1'b0, w);
    n1 = edges;
    issue(0, 3, 4, 11, 2, 2, 1'b1, 1'b1, w);
    check("t1 accept spacing", 32'(w), 32'd2);
    while (!o_rwen[0] && edges - n1 < 20) cycle();
    check("t1 write latency", 32'(edges - n1), 32'd4);
    check("t1 write row", 32'(o_raddr[0]), 32'd10);
    check("t1 issue_cnt", 32'(o_ic[0]), 32'd2);
    drain(0);

    // RAW hazard: consumer held until the producer reaches STORE
    base = m_sc[0];
    issue(0, 7, 8, 5, 3, 0, 1'b1, 1'b0, w);
    issue(0, 5, 6, 20, 4, 1, 1'b1, 1'b0, w);
    check("t2 hold cycles", 32'(w), 32'd6);
    check("t2 stall delta", 32'(o_sc[0]) - 32'(base), 32'd2);
    check("t2 load a after accept", 32'(o_aaddr[0]), 32'd5);
    drain(0);

    // Interval 1, three EXEC stages: back-to-back stream
    for (int i = 0; i < 8; i++) begin
      issue(1, 100 + i, 200 + i, 300 + i, i, i, 1'b1, 1'(i), w);
      check("t3 one per cycle", 32'(w), 32'd1);
      if (i == 0) n1 = edges;
      if (i == 4) begin
        check("t3 first write", 32'(o_rwen[1]), 32'd1);
        check("t3 first write row", 32'(o_raddr[1]), 32'd300);
      end
    end
    nl = edges;
    while (o_busy[1] && edges - nl < 20) cycle();
    check("t3 busy drop", 32'(edges - nl), 32'd5);

    // Flush with two in flight and a handshake in the same cycle
    base = m_ic[0];
    issue(0, 1, 2, 30, 1, 0, 1'b1, 1'b0, w);
    issue(0, 3, 4, 31, 1, 0, 1'b1, 1'b0, w);
    cycle();
    set_in(0, 1'b1, 5, 6, 32, 1, 0, 1'b1, 1'b0);
    ifl[0] = 1'b1;
    check("t4 handshake before flush", 32'(o_ready[0]), 32'd1);
    cycle();
    ifl[0] = 1'b0;
    iv[0] = 1'b0;
    check("t4 busy after flush", 32'(o_busy[0]), 32'd0);
    check("t4 issue_cnt", 32'(o_ic[0]), 32'(base + 2));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (o_rwen[0]) seen++;
    end
    check("t4 no write", 32'(seen), 32'd0);

    // Asynchronous reset while STORE holds a write
    issue(0, 1, 2, 40, 1, 0, 1'b1, 1'b1, w);
    n1 = edges;
    while (!o_rwen[0] && edges - n1 < 20) cycle();
    check("t5 store reached", 32'(o_rwen[0]), 32'd1);
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    check("t5 wen drop", 32'(o_rwen[0]), 32'd0);
    for (int k = 0; k < 3; k++) check_outputs(k);
    #1;
    rstn = 1'b1;
    n1 = edges;
    while (!o_adv[0] && edges - n1 < 10) cycle();
    check("t5 first adv edges", 32'(edges - n1), 32'd1);

    // 2-bit counters, hazard check disabled: self-dependent instructions never stall
    for (int i = 0; i < 5; i++) issue(2, 40, 40, 40, i, 0, 1'b1, 1'b0, w);
    check("t6 issue_cnt sat", 32'(o_ic[2]), 32'd3);
    check("t6 stall_cnt", 32'(o_sc[2]), 32'd0);

    // Random traffic on all three instances, small address space to provoke hazards
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < 3; k++) begin
        set_in(k, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        ifl[k] = ($urandom_range(0, 19) == 0);
      end
      cycle();
    end
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      ifl[k] = 1'b0;
    end
    for (int k = 0; k < 3; k++) drain(k);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
